// File: rtl/radix4_operand_feeder.sv
// Radix-4 operand feeder: buffers a 16-point complex frame, then issues four
// butterfly operand sets (x1..x4 plus twiddles W^n, W^2n, W^3n) from registers.
module radix4_operand_feeder #(
    parameter int N_POINT = 16,
    parameter int TW_FRAC = 14
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_re,
    input  logic [15:0] in_im,
    output logic [15:0] x1_re,
    output logic [15:0] x1_im,
    output logic [15:0] x2_re,
    output logic [15:0] x2_im,
    output logic [15:0] x3_re,
    output logic [15:0] x3_im,
    output logic [15:0] x4_re,
    output logic [15:0] x4_im,
    output logic [15:0] cos0,
    output logic [15:0] sin0,
    output logic [15:0] cos1,
    output logic [15:0] sin1,
    output logic [15:0] cos2,
    output logic [15:0] sin2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last
);

    localparam logic [15:0] TW_ONE = 16'(1 << TW_FRAC);

    typedef enum logic {FILL, ISSUE} state_t;

    // Each entry packs {re, im}.
    typedef logic [31:0] cplx_t;

    state_t                    state_q;
    logic   [3:0]              wr_cnt_q;
    logic   [1:0]              n_q;
    cplx_t  [N_POINT-1:0]      buf_q;
    cplx_t  [3:0]              ops_q;
    cplx_t  [3:0]              ops_d;
    cplx_t  [2:0]              tw_q;
    cplx_t  [2:0]              tw_d;
    logic                      out_valid_q;
    logic                      out_last_q;
    logic   [1:0]              grp_d;
    logic   [3:0]              base_d;
    logic   [3:0]              k1_d;
    logic   [3:0]              k2_d;
    logic   [3:0]              k3_d;
    logic                      wr_en;
    logic                      consume;

    // Q1.14 twiddle ROM, {cos, -sin}; only the exponents a 16-point radix-4
    // stage ever needs are populated.
    function automatic cplx_t tw_rom(input logic [3:0] k);
        cplx_t r;
        case (k)
            4'd0:    r = {TW_ONE, 16'sd0};
            4'd1:    r = {16'sd15137, -16'sd6270};
            4'd2:    r = {16'sd11585, -16'sd11585};
            4'd3:    r = {16'sd6270, -16'sd15137};
            4'd4:    r = {16'sd0, -16'sd16384};
            4'd6:    r = {-16'sd11585, -16'sd11585};
            4'd9:    r = {-16'sd15137, 16'sd6270};
            default: r = '0;
        endcase
        return r;
    endfunction

    assign in_ready = (state_q == FILL);
    assign wr_en    = !rst && (state_q == FILL) && in_valid;
    assign consume  = (state_q == ISSUE) && out_ready;

    // Operands are preloaded for the group about to be shown: group 0 on the
    // edge that completes the fill, otherwise the group after the current one.
    always_comb begin
        grp_d  = (state_q == FILL) ? 2'd0 : n_q + 2'd1;
        base_d = {grp_d, 2'b00};
        k1_d   = {2'b00, grp_d};
        k2_d   = {1'b0, grp_d, 1'b0};
        k3_d   = k1_d + k2_d;
        ops_d  = '0;
        for (int j = 0; j < 4; j++) begin
            ops_d[j] = buf_q[base_d + 4'(j)];
        end
        tw_d    = '0;
        tw_d[0] = tw_rom(k1_d);
        tw_d[1] = tw_rom(k2_d);
        tw_d[2] = tw_rom(k3_d);
    end

    // Frame buffer is not reset; wr_cnt restarts so a full refill always
    // precedes the next issue.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_q[wr_cnt_q] <= {in_re, in_im};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            wr_cnt_q    <= '0;
            n_q         <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            ops_q       <= '0;
            tw_q        <= '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (in_valid) begin
                        wr_cnt_q <= wr_cnt_q + 4'd1;
                        if (wr_cnt_q == 4'd15) begin
                            state_q     <= ISSUE;
                            n_q         <= 2'd0;
                            out_valid_q <= 1'b1;
                            out_last_q  <= 1'b0;
                            ops_q       <= ops_d;
                            tw_q        <= tw_d;
                        end
                    end
                end
                ISSUE: begin
                    if (consume) begin
                        if (n_q == 2'd3) begin
                            state_q     <= FILL;
                            n_q         <= 2'd0;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                        end else begin
                            n_q        <= n_q + 2'd1;
                            out_last_q <= (n_q == 2'd2);
                            ops_q      <= ops_d;
                            tw_q       <= tw_d;
                        end
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign x1_re = ops_q[0][31:16];
    assign x1_im = ops_q[0][15:0];
    assign x2_re = ops_q[1][31:16];
    assign x2_im = ops_q[1][15:0];
    assign x3_re = ops_q[2][31:16];
    assign x3_im = ops_q[2][15:0];
    assign x4_re = ops_q[3][31:16];
    assign x4_im = ops_q[3][15:0];

    assign cos0 = tw_q[0][31:16];
    assign sin0 = tw_q[0][15:0];
    assign cos1 = tw_q[1][31:16];
    assign sin1 = tw_q[1][15:0];
    assign cos2 = tw_q[2][31:16];
    assign sin2 = tw_q[2][15:0];

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_radix4_operand_feeder.sv
// Directed bench for radix4_operand_feeder: ramp, backpressure, input gaps,
// reset mid-issue, back-to-back frames and extreme values.
module tb_radix4_operand_feeder;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic        [15:0] in_re;
    logic        [15:0] in_im;
    logic signed [15:0] x1_re, x1_im, x2_re, x2_im, x3_re, x3_im, x4_re, x4_im;
    logic signed [15:0] cos0, sin0, cos1, sin1, cos2, sin2;
    logic               out_valid;
    logic               out_ready;
    logic               out_last;

    int checks = 0;
    int errors = 0;

    radix4_operand_feeder #(.N_POINT(16), .TW_FRAC(14)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
        .x1_re(x1_re), .x1_im(x1_im), .x2_re(x2_re), .x2_im(x2_im),
        .x3_re(x3_re), .x3_im(x3_im), .x4_re(x4_re), .x4_im(x4_im),
        .cos0(cos0), .sin0(sin0), .cos1(cos1), .sin1(sin1), .cos2(cos2), .sin2(sin2),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int base_re, input int base_im);
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_re    = 16'(base_re + i);
            in_im    = 16'(base_im + i);
            tick();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int sets;
        rst = 1'b1; in_valid = 1'b0; in_re = '0; in_im = '0; out_ready = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_x1_re", x1_re, 0);
        chk("rst_cos0", cos0, 0);
        chk("rst_sin2", sin2, 0);
        rst = 1'b0;

        // Ramp frame
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            in_valid = 1'b1; in_re = 16'(i); in_im = 16'(100 + i);
            tick();
        end
        chk("ramp_pre_valid", out_valid, 0);
        chk("ramp_pre_ready", in_ready, 1);
        in_re = 16'd15; in_im = 16'd115;
        tick();
        in_valid = 1'b0;
        chk("ramp_n0_valid", out_valid, 1);
        chk("ramp_n0_inready", in_ready, 0);
        chk("ramp_n0_x1re", x1_re, 0);
        chk("ramp_n0_x2re", x2_re, 1);
        chk("ramp_n0_x3im", x3_im, 102);
        chk("ramp_n0_cos0", cos0, 16384);
        chk("ramp_n0_sin0", sin0, 0);
        chk("ramp_n0_last", out_last, 0);
        tick();
        chk("ramp_n1_x1re", x1_re, 4);
        chk("ramp_n1_x4re", x4_re, 7);
        chk("ramp_n1_x4im", x4_im, 107);
        chk("ramp_n1_cos0", cos0, 15137);
        chk("ramp_n1_sin0", sin0, -6270);
        chk("ramp_n1_sin1", sin1, -11585);
        chk("ramp_n1_cos2", cos2, 6270);
        chk("ramp_n1_last", out_last, 0);
        tick();
        chk("ramp_n2_x1re", x1_re, 8);
        chk("ramp_n2_cos1", cos1, 0);
        chk("ramp_n2_sin1", sin1, -16384);
        chk("ramp_n2_last", out_last, 0);
        tick();
        chk("ramp_n3_x1re", x1_re, 12);
        chk("ramp_n3_x4im", x4_im, 115);
        chk("ramp_n3_last", out_last, 1);
        chk("ramp_n3_cos2", cos2, -15137);
        chk("ramp_n3_sin2", sin2, 6270);
        tick();
        chk("ramp_end_valid", out_valid, 0);
        chk("ramp_end_last", out_last, 0);
        chk("ramp_end_inready", in_ready, 1);

        // Backpressure at n=2
        feed(0, 100);
        tick(); tick();
        out_ready = 1'b0;
        in_valid = 1'b1; in_re = 16'd999; in_im = 16'd999;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_x1re", x1_re, 8);
            chk("bp_cos2", cos2, -11585);
            chk("bp_sin2", sin2, -11585);
            chk("bp_valid", out_valid, 1);
            chk("bp_inready", in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_n3_x1re", x1_re, 12);
        chk("bp_n3_inready", in_ready, 0);
        tick();
        chk("bp_after_inready", in_ready, 1);
        chk("bp_after_valid", out_valid, 0);
        in_valid = 1'b0;

        // Input gaps: valid on even cycles only, downstream stalled
        out_ready = 1'b0;
        for (int c = 0; c < 32; c++) begin
            in_valid = ~c[0];
            in_re    = 16'(300 + c / 2);
            in_im    = 16'(-(c / 2));
            tick();
            if (c == 29) chk("gap_pre_valid", out_valid, 0);
            if (c == 30) chk("gap_first_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        chk("gap_x1re", x1_re, 300);
        chk("gap_x2re", x2_re, 301);
        chk("gap_x4im", x4_im, -3);
        out_ready = 1'b1;
        tick();
        chk("gap_n1_x1re", x1_re, 304);
        chk("gap_n1_x1im", x1_im, -4);
        tick(); tick();
        chk("gap_n3_x4re", x4_re, 315);
        tick();
        chk("gap_end_valid", out_valid, 0);

        // Reset mid-ISSUE at n=1, with a handshake pending
        feed(500, 600);
        tick();
        chk("rmid_n1_x1re", x1_re, 504);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rmid_valid", out_valid, 0);
        chk("rmid_inready", in_ready, 1);
        chk("rmid_x1re", x1_re, 0);
        chk("rmid_last", out_last, 0);
        // Partial fill then reset with a sample offered
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_re = 16'(900 + i); in_im = 16'(900 + i);
            tick();
        end
        rst = 1'b1; in_re = 16'd950;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        chk("rfill_valid", out_valid, 0);
        feed(200, 250);
        chk("rnew_x1re", x1_re, 200);
        chk("rnew_x4re", x4_re, 203);
        chk("rnew_x1im", x1_im, 250);
        tick(); tick(); tick();
        chk("rnew_n3_x1re", x1_re, 212);
        tick();

        // Back-to-back frames
        sets = 0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (c < 16)      in_re = 16'(1000 + c);
            else if (c < 20) in_re = 16'd7777;
            else if (c < 36) in_re = 16'(2000 + c - 20);
            else             in_re = 16'd7777;
            in_im = 16'(-int'(in_re));
            tick();
            if (out_valid) sets++;
            if (c == 18) begin
                chk("b2b_f0_x1re", x1_re, 1012);
                chk("b2b_f0_cos2", cos2, -15137);
                chk("b2b_f0_sin2", sin2, 6270);
            end
            if (c == 38) begin
                chk("b2b_f1_x1re", x1_re, 2012);
                chk("b2b_f1_x1im", x1_im, -2012);
                chk("b2b_f1_cos2", cos2, -15137);
                chk("b2b_f1_sin2", sin2, 6270);
            end
        end
        in_valid = 1'b0;
        chk("b2b_sets", sets, 8);
        chk("b2b_end_valid", out_valid, 0);

        // Extremes
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_re = (i % 2 == 0) ? 16'h8000 : 16'h7FFF;
            in_im = (i % 2 == 0) ? 16'h7FFF : 16'h8000;
            tick();
        end
        in_valid = 1'b0;
        chk("ext_x1re", x1_re, -32768);
        chk("ext_x1im", x1_im, 32767);
        chk("ext_x2re", x2_re, 32767);
        chk("ext_x2im", x2_im, -32768);
        tick(); tick(); tick();
        chk("ext_n3_x4re", x4_re, 32767);
        tick();
        chk("ext_end_valid", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
